// File: rtl/usbfs_pkg.sv
// Shared definitions for the USB FS host token path: token PIDs, packet length, FSM states.
package usbfs_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  localparam int unsigned TOKEN_BITS = 24;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StShift,
    StDone
  } tok_state_e;

  function automatic logic is_token_pid(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SOF) || (pid == PID_SETUP);
  endfunction

endpackage

// File: rtl/usbfs_crc5.sv
// USB CRC5 (x^5+x^2+1, seed 5'b11111) over an 11-bit token field taken LSB first.
// Output is the inverted remainder, ready to be sent MSB first.
module usbfs_crc5 (
  input  logic [10:0] data_i,
  output logic [4:0]  crc_o
);

  logic [4:0] crc;

  always_comb begin
    crc = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      if (data_i[i] ^ crc[4]) begin
        crc = {crc[3:0], 1'b0} ^ 5'b00101;
      end else begin
        crc = {crc[3:0], 1'b0};
      end
    end
    crc_o = ~crc;
  end

endmodule

// File: rtl/usbfs_host_token_tx.sv
// Host-side USB FS token generator: builds OUT/IN/SETUP/SOF tokens and shifts them out LSB first.
// Define USBFS_HOST_SOF_EN to include the automatic 1 ms SOF timer.
module usbfs_host_token_tx #(
  parameter int unsigned SOF_PERIOD = 60000,
  parameter logic [10:0] FRAME_INIT = 11'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_pid_i,
  input  logic [6:0]  cmd_addr_i,
  input  logic [3:0]  cmd_endp_i,
  output logic        cmd_err_o,
  input  logic        sof_enable_i,
  output logic        sof_pulse_o,
  output logic [10:0] frame_num_o,
  output logic        busy_o,
  output logic        tx_sta_o,
  input  logic        tx_req_i,
  output logic        tx_bit_o,
  output logic        tx_fin_o
);

  import usbfs_pkg::*;

  tok_state_e  state_q, state_d;
  logic [23:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [10:0] frame_q, frame_next;
  logic        sof_due, sof_launch, cmd_hs;
  logic [3:0]  ld_pid;
  logic [10:0] ld_field;
  logic [4:0]  crc;

`ifdef USBFS_HOST_SOF_EN
  localparam int unsigned TimerW = (SOF_PERIOD > 1) ? $clog2(SOF_PERIOD) : 1;

  logic [TimerW-1:0] timer_q, timer_d;
  logic              pend_q, pend_d;
  logic [10:0]       frame_d;
  logic              tc;

  assign tc = sof_enable_i && (timer_q == TimerW'(SOF_PERIOD - 1));

  always_comb begin
    timer_d = '0;
    if (sof_enable_i && !tc) begin
      timer_d = timer_q + 1'b1;
    end
    // A new terminal count while one is still pending simply merges into it.
    pend_d  = (pend_q && !sof_launch) || tc;
    frame_d = sof_launch ? frame_next : frame_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
      pend_q  <= 1'b0;
      frame_q <= FRAME_INIT;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
    end
  end

  assign sof_due = pend_q;
`else
  logic unused_sof_enable;
  assign unused_sof_enable = sof_enable_i;
  assign frame_q           = FRAME_INIT;
  assign sof_due           = 1'b0;
`endif

  assign frame_next = frame_q + 11'd1;
  assign sof_launch = (state_q == StIdle) && sof_due && !rst_i;
  assign cmd_ready_o = (state_q == StIdle) && !sof_due && !rst_i;
  assign cmd_hs     = cmd_ready_o && cmd_valid_i;

  // Address sits in the low 7 field bits, so tokens and SOF share one field layout.
  assign ld_pid   = sof_launch ? PID_SOF : cmd_pid_i;
  assign ld_field = sof_launch ? frame_next : {cmd_endp_i, cmd_addr_i};

  usbfs_crc5 u_crc5 (
    .data_i (ld_field),
    .crc_o  (crc)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sof_launch || (cmd_hs && is_token_pid(cmd_pid_i))) begin
          sr_d    = {crc[0], crc[1], crc[2], crc[3], crc[4], ld_field, ~ld_pid, ld_pid};
          cnt_d   = '0;
          state_d = StStart;
        end else if (cmd_hs) begin
          err_d = 1'b1;
        end
      end
      StStart: state_d = StShift;
      StShift: begin
        if (tx_req_i) begin
          sr_d  = {1'b0, sr_q[23:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(TOKEN_BITS - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cmd_err_o   = err_q;
  assign sof_pulse_o = sof_launch;
  assign frame_num_o = frame_q;
  assign busy_o      = (state_q != StIdle);
  assign tx_sta_o    = (state_q == StStart);
  assign tx_bit_o    = sr_q[0];
  assign tx_fin_o    = (state_q == StShift) && tx_req_i && (cnt_q == 5'(TOKEN_BITS - 1));

endmodule

// File: tb/tb_usbfs_host_token_tx.sv
// Directed bench for usbfs_host_token_tx with a scoreboard of expected 24-bit tokens.
module tb_usbfs_host_token_tx;

  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_SOF   = 4'b0101;
  localparam logic [3:0] P_SETUP = 4'b1101;
  localparam logic [3:0] P_DATA0 = 4'b0011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_pid = '0;
  logic [6:0]  cmd_addr = '0;
  logic [3:0]  cmd_endp = '0;
  logic        sof_enable = 1'b0;
  logic        tx_req = 1'b0;
  logic        cmd_ready, cmd_err, sof_pulse, busy, tx_sta, tx_bit, tx_fin;
  logic [10:0] frame_num;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sof_pulses = 0;
  logic [23:0] exp_q[$];

  usbfs_host_token_tx #(
    .SOF_PERIOD (100),
    .FRAME_INIT (11'd2046)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_pid_i    (cmd_pid),
    .cmd_addr_i   (cmd_addr),
    .cmd_endp_i   (cmd_endp),
    .cmd_err_o    (cmd_err),
    .sof_enable_i (sof_enable),
    .sof_pulse_o  (sof_pulse),
    .frame_num_o  (frame_num),
    .busy_o       (busy),
    .tx_sta_o     (tx_sta),
    .tx_req_i     (tx_req),
    .tx_bit_o     (tx_bit),
    .tx_fin_o     (tx_fin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sof_pulse) sof_pulses <= sof_pulses + 1;
  end

  function automatic logic [4:0] ref_crc5(input logic [10:0] d);
    logic [4:0] c;
    logic fb;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    return ~c;
  endfunction

  function automatic logic [23:0] ref_tok(input logic [3:0] pid, input logic [10:0] field);
    logic [23:0] w;
    logic [4:0] c;
    c = ref_crc5(field);
    w[7:0]  = {~pid, pid};
    w[18:8] = field;
    for (int k = 0; k < 5; k++) w[19+k] = c[4-k];
    return w;
  endfunction

  function automatic bit tb_is_tok(input logic [3:0] pid);
    return (pid == P_OUT) || (pid == P_IN) || (pid == P_SOF) || (pid == P_SETUP);
  endfunction

  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    bit hs;
    hs = 1'b0;
    cmd_valid = 1'b1;
    cmd_pid   = pid;
    cmd_addr  = addr;
    cmd_endp  = endp;
    #1;
    for (int n = 0; n < 300; n++) begin
      if (cmd_ready) begin
        hs = 1'b1;
        break;
      end
      nx();
    end
    chk("handshake", {31'd0, hs}, 32'd1);
    if (tb_is_tok(pid)) exp_q.push_back(ref_tok(pid, {endp, addr}));
    nx();
    cmd_valid = 1'b0;
    if (tb_is_tok(pid)) begin
      chk("sta_latency", {31'd0, tx_sta}, 32'd1);
      chk("busy_at_sta", {31'd0, busy}, 32'd1);
    end else begin
      chk("cmd_err_pulse", {31'd0, cmd_err}, 32'd1);
      chk("no_sta_on_err", {31'd0, tx_sta}, 32'd0);
    end
  endtask

  task automatic rx_packet(input int nbits, input int gap, output logic [23:0] w);
    bit got;
    int fin_early, fin_last, rdy_busy;
    logic [23:0] e;
    got = 1'b0;
    fin_early = 0;
    fin_last = 0;
    rdy_busy = 0;
    w = '0;
    e = 'x;
    for (int n = 0; n < 300; n++) begin
      if (tx_sta) begin
        got = 1'b1;
        break;
      end
      nx();
    end
    chk("sta_seen", {31'd0, got}, 32'd1);
    if (!got) return;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    for (int i = 0; i < nbits; i++) begin
      nx();
      tx_req = 1'b1;
      #1;
      w[i] = tx_bit;
      if (tx_fin) begin
        if (i == 23) fin_last++;
        else fin_early++;
      end
      if (cmd_ready && busy) rdy_busy++;
      if (i < nbits - 1) begin
        repeat (gap) begin
          nx();
          tx_req = 1'b0;
        end
      end
    end
    nx();
    tx_req = 1'b0;
    chk("fin_early", fin_early, 0);
    chk("ready_while_busy", rdy_busy, 0);
    if (nbits == 24) begin
      chk("fin_last", fin_last, 1);
      chk("packet_bits", {8'd0, w}, {8'd0, e});
      chk("busy_in_done", {31'd0, busy}, 32'd1);
      nx();
      chk("busy_dropped", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic wait_pulse(output int t);
    bit got;
    got = 1'b0;
    t = 0;
    for (int n = 0; n < 300; n++) begin
      if (sof_pulse) begin
        got = 1'b1;
        t = cyc;
        break;
      end
      nx();
    end
    chk("sof_pulse_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    logic [23:0] w;
    int t0, t1, t2, t3, t4, nfin, nsta;

    repeat (3) nx();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_sta", {31'd0, tx_sta}, 32'd0);
    chk("rst_tx_fin", {31'd0, tx_fin}, 32'd0);
    chk("rst_tx_bit", {31'd0, tx_bit}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_sof_pulse", {31'd0, sof_pulse}, 32'd0);
    chk("rst_frame_num", {21'd0, frame_num}, 32'd2046);
    rst = 1'b0;
    nx();
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    send_cmd(P_SETUP, 7'd0, 4'd0);
    rx_packet(24, 0, w);
    chk("setup_bytes", {8'd0, w}, 32'h0010002D);

    send_cmd(P_IN, 7'd1, 4'd0);
    rx_packet(24, 1, w);
    chk("in_bytes", {8'd0, w}, 32'h00E80169);

    send_cmd(P_OUT, 7'd1, 4'd0);
    rx_packet(24, 2, w);
    chk("out_bytes", {8'd0, w}, 32'h00E801E1);

    send_cmd(P_SOF, 7'h7F, 4'hF);
    rx_packet(24, 0, w);

    send_cmd(P_DATA0, 7'h12, 4'h3);
    nx();
    chk("cmd_err_one_cycle", {31'd0, cmd_err}, 32'd0);
    chk("idle_after_err", {31'd0, busy}, 32'd0);
    chk("no_sta_after_err", {31'd0, tx_sta}, 32'd0);

    // Abandon a packet by reset while bit 10 is pending.
    send_cmd(P_IN, 7'd5, 4'd2);
    rx_packet(10, 0, w);
    rst = 1'b1;
    nx();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_tx_bit", {31'd0, tx_bit}, 32'd0);
    chk("midrst_tx_sta", {31'd0, tx_sta}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    nfin = 0;
    nsta = 0;
    for (int i = 0; i < 30; i++) begin
      nx();
      tx_req = 1'b1;
      #1;
      if (tx_fin) nfin++;
      if (tx_sta) nsta++;
    end
    tx_req = 1'b0;
    chk("midrst_no_fin", nfin, 0);
    chk("midrst_no_sta", nsta, 0);
    chk("midrst_ready_back", {31'd0, cmd_ready}, 32'd1);

`ifdef USBFS_HOST_SOF_EN
    sof_enable = 1'b1;
    t0 = cyc;
    wait_pulse(t1);
    chk("sof_first_delay", t1 - t0, 100);
    exp_q.push_back(ref_tok(P_SOF, 11'd2047));
    rx_packet(24, 0, w);
    chk("frame_2047", {21'd0, frame_num}, 32'd2047);

    wait_pulse(t2);
    chk("sof_period_a", t2 - t1, 100);
    exp_q.push_back(ref_tok(P_SOF, 11'd0));
    rx_packet(24, 0, w);
    chk("frame_wrap", {21'd0, frame_num}, 32'd0);

    // Command raised in the very cycle the SOF is launched: SOF goes first.
    wait_pulse(t3);
    chk("sof_period_b", t3 - t2, 100);
    cmd_valid = 1'b1;
    cmd_pid   = P_IN;
    cmd_addr  = 7'd5;
    cmd_endp  = 4'd2;
    #1;
    chk("sof_beats_cmd", {31'd0, cmd_ready}, 32'd0);
    exp_q.push_back(ref_tok(P_SOF, 11'd1));
    exp_q.push_back(ref_tok(P_IN, {4'd2, 7'd5}));
    rx_packet(24, 0, w);
    chk("ready_after_sof", {31'd0, cmd_ready}, 32'd1);
    nx();
    cmd_valid = 1'b0;
    rx_packet(24, 0, w);

    // Slow OUT packet straddles the next terminal count.
    send_cmd(P_OUT, 7'd3, 4'd1);
    rx_packet(24, 1, w);
    chk("sof_after_done", {31'd0, sof_pulse}, 32'd1);
    chk("ready_blocked_by_sof", {31'd0, cmd_ready}, 32'd0);
    t4 = cyc;
    chk("sof_was_deferred", {31'd0, (t4 - t3) > 100}, 32'd1);
    exp_q.push_back(ref_tok(P_SOF, 11'd2));
    rx_packet(24, 0, w);
    chk("frame_2", {21'd0, frame_num}, 32'd2);
    sof_enable = 1'b0;
    nx();
    chk("sof_pulse_count", sof_pulses, 4);
`else
    chk("frame_const", {21'd0, frame_num}, 32'd2046);
    chk("no_auto_sof", sof_pulses, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
